// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI slave register-bus controller.
package spi_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ACC  = 3'd1;
  localparam logic [2:0] S_RD_HOLD = 3'd2;
  localparam logic [2:0] S_WR_ARM  = 3'd3;
  localparam logic [2:0] S_WR_ACC  = 3'd4;

  localparam int ST_WR    = 2;
  localparam int ST_BURST = 1;

  localparam int ERR_RD_LATE = 0;
  localparam int ERR_TMO     = 1;
  localparam int ERR_OVR     = 2;

  localparam logic [15:0] RD_TMO_VAL = 16'hFFFF;

  typedef logic [2:0] err_t;

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchroniser with a parameterised reset value.
module spi_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_bus_ctrl.sv
// rtl/spi_bus_ctrl.sv - sequences register-bus reads/writes for SPI frames.
// Optional per-access timeout is enabled by defining SPI_BUS_TIMEOUT_EN.
module spi_bus_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              address_ready,
  input  logic              data_ready,
  input  logic              miso_start,
  input  logic [19:0]       spi_addr,
  input  logic [3:0]        spi_status,
  input  logic [15:0]       spi_wdata,
  output logic [15:0]       rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [15:0]       bus_rdata,
  output logic              busy,
  output logic [2:0]        err
);

  logic              cs_s;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              burst_q, burst_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  err_t              err_q, err_d;
  logic              done;
  logic              tmo_hit;
  logic              unused_status;

  assign unused_status = spi_status[3] ^ spi_status[0];

  spi_sync2 #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (cs_n),
    .q_o   (cs_s)
  );

`ifdef SPI_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q;

  // Counter idles at zero whenever no request is outstanding, so it restarts on every access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (req_q && !done) cnt_q <= cnt_q + CNT_W'(1);
    else cnt_q <= '0;
  end

  assign tmo_hit = req_q && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (address_ready && !cs_s) begin
          addr_d  = spi_addr[ADDR_W-1:0];
          burst_d = spi_status[ST_BURST] & spi_status[ST_WR];
          err_d   = '0;
          if (spi_status[ST_WR]) begin
            state_d = S_WR_ARM;
          end else begin
            state_d = S_RD_ACC;
            req_d   = 1'b1;
            we_d    = 1'b0;
          end
        end
      end
      S_RD_ACC: begin
        if (miso_start) err_d[ERR_RD_LATE] = 1'b1;
        if (bus_ack) begin
          rdata_d = bus_rdata;
          done    = 1'b1;
        end else if (tmo_hit) begin
          rdata_d        = RD_TMO_VAL;
          err_d[ERR_TMO] = 1'b1;
          done           = 1'b1;
        end
        if (done) begin
          req_d   = 1'b0;
          state_d = cs_s ? S_IDLE : S_RD_HOLD;
        end
      end
      S_RD_HOLD: begin
        if (cs_s) state_d = S_IDLE;
      end
      S_WR_ARM: begin
        if (cs_s) begin
          state_d = S_IDLE;
        end else if (data_ready) begin
          wdata_d = spi_wdata;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = S_WR_ACC;
        end
      end
      S_WR_ACC: begin
        if (data_ready) err_d[ERR_OVR] = 1'b1;
        if (bus_ack) begin
          done = 1'b1;
        end else if (tmo_hit) begin
          err_d[ERR_TMO] = 1'b1;
          done           = 1'b1;
        end
        if (done) begin
          req_d = 1'b0;
          if (burst_q && !cs_s) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_WR_ARM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      burst_q <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata     = rdata_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// tb/tb_spi_bus_ctrl.sv - scoreboard bench for spi_bus_ctrl.
module tb_spi_bus_ctrl;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic        address_ready;
  logic        data_ready;
  logic        miso_start;
  logic [19:0] spi_addr;
  logic [3:0]  spi_status;
  logic [15:0] spi_wdata;
  logic [15:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [19:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        busy;
  logic [2:0]  err;

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  int cyc = 0;
  int last_len = 0;
  bit rd_pending = 0;
  acc_t        exp_q[$];
  logic [15:0] rd_q[$];

  spi_bus_ctrl #(.ADDR_W(20), .TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs_n          (cs_n),
    .address_ready (address_ready),
    .data_ready    (data_ready),
    .miso_start    (miso_start),
    .spi_addr      (spi_addr),
    .spi_status    (spi_status),
    .spi_wdata     (spi_wdata),
    .rdata         (rdata),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus slave and scoreboard: acks after ack_delay request cycles (0 = never).
  initial begin
    acc_t        e;
    logic [15:0] r;
    bus_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        rd_pending = 0;
        check_val("rd_q_nonempty", rd_q.size(), (rd_q.size() == 0) ? 1 : rd_q.size());
        r = (rd_q.size() != 0) ? rd_q.pop_front() : 16'h0;
        check_val("rdata", rdata, r);
      end
      if (bus_req) cyc++;
      else cyc = 0;
      bus_ack = 1'b0;
      if (bus_req && ack_delay != 0 && cyc == ack_delay) begin
        bus_ack  = 1'b1;
        last_len = cyc;
        if (exp_q.size() == 0) begin
          check_val("unexpected_access", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_val("acc_we", bus_we, e.we);
          check_val("acc_addr", bus_addr, e.addr);
          if (e.we) check_val("acc_wdata", bus_wdata, e.wdata);
          else rd_pending = 1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input logic [19:0] a, input logic [3:0] st);
    cs_n = 1'b0;
    tick(3);
    address_ready = 1'b1;
    spi_addr      = a;
    spi_status    = st;
    tick();
    address_ready = 1'b0;
  endtask

  task automatic wait_req_low(input string tag);
    for (int i = 0; i < 100 && bus_req; i++) tick();
    check_val(tag, bus_req, 1'b0);
  endtask

  task automatic end_frame(input string tag);
    cs_n = 1'b1;
    for (int i = 0; i < 100 && busy; i++) tick();
    check_val(tag, busy, 1'b0);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 100 && bus_req; i++) tick();
    data_ready = 1'b1;
    spi_wdata  = w;
    tick();
    data_ready = 1'b0;
    wait_req_low("wr_req_drop");
  endtask

  task automatic push_acc(input logic we, input logic [19:0] a, input logic [15:0] w);
    acc_t e;
    e.we = we; e.addr = a; e.wdata = w;
    exp_q.push_back(e);
  endtask

  initial begin
    int n;
    reset = 1'b1; cs_n = 1'b1; address_ready = 1'b0; data_ready = 1'b0;
    miso_start = 1'b0; spi_addr = '0; spi_status = '0; spi_wdata = '0;
    bus_rdata = '0;
    tick(2);
    check_val("rst_outs", {rdata, bus_req, bus_we, busy, err}, 32'h0);
    check_val("rst_bus", {bus_addr, bus_wdata}, 36'h0);
    reset = 1'b0;
    tick(2);

    // Single read, ack in third request cycle
    ack_delay = 3; bus_rdata = 16'hA5C3;
    push_acc(1'b0, 20'h00123, 16'h0); rd_q.push_back(16'hA5C3);
    start_frame(20'h00123, 4'b0000);
    wait_req_low("rd_req_drop");
    check_val("rd_len", last_len, 3);
    tick();
    check_val("rd_err", err, 3'b000);
    miso_start = 1'b1; tick(); miso_start = 1'b0;
    check_val("rd_hold_err", err, 3'b000);
    check_val("rd_hold_busy", busy, 1'b1);
    end_frame("rd_end_idle");

    // Single write, immediate ack
    ack_delay = 1;
    push_acc(1'b1, 20'h00040, 16'h1234);
    start_frame(20'h00040, 4'b0100);
    send_word(16'h1234);
    check_val("wr_len", last_len, 1);
    check_val("wr_idle", busy, 1'b0);
    cs_n = 1'b1; tick(3);

    // Burst write across address wrap
    ack_delay = 2;
    push_acc(1'b1, 20'hFFFFE, 16'h0001);
    push_acc(1'b1, 20'hFFFFF, 16'h0002);
    push_acc(1'b1, 20'h00000, 16'h0003);
    start_frame(20'hFFFFE, 4'b0110);
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'h0003);
    check_val("burst_armed", busy, 1'b1);
    check_val("burst_err", err, 3'b000);
    end_frame("burst_end_idle");

    // Late read: miso_start while access pending
    ack_delay = 4; bus_rdata = 16'h5A5A;
    push_acc(1'b0, 20'h00200, 16'h0); rd_q.push_back(16'h5A5A);
    start_frame(20'h00200, 4'b0000);
    tick();
    miso_start = 1'b1; tick(); miso_start = 1'b0;
    wait_req_low("late_req_drop");
    check_val("late_err", err, 3'b001);
    tick();
    end_frame("late_end_idle");

    // Overrun during a burst write: second word dropped
    ack_delay = 4;
    push_acc(1'b1, 20'h00300, 16'hBEEF);
    start_frame(20'h00300, 4'b0110);
    data_ready = 1'b1; spi_wdata = 16'hBEEF; tick();
    spi_wdata = 16'hDEAD; tick();
    data_ready = 1'b0;
    wait_req_low("ovr_req_drop");
    check_val("ovr_err", err, 3'b100);
    tick(3);
    check_val("ovr_dropped", bus_req, 1'b0);
    end_frame("ovr_end_idle");

    // cs_n rises mid read: access finishes, then idle
    ack_delay = 5; bus_rdata = 16'h0F0F;
    push_acc(1'b0, 20'h00077, 16'h0); rd_q.push_back(16'h0F0F);
    start_frame(20'h00077, 4'b0000);
    cs_n = 1'b1;
    wait_req_low("abort_req_drop");
    check_val("abort_len", last_len, 5);
    check_val("abort_idle", busy, 1'b0);
    check_val("abort_err", err, 3'b000);
    tick(2);

`ifdef SPI_BUS_TIMEOUT_EN
    ack_delay = 0;
    start_frame(20'h00500, 4'b0000);
    n = 0;
    while (bus_req && n < 50) begin n++; tick(); end
    check_val("tmo_len", n, 8);
    check_val("tmo_err", err, 3'b010);
    check_val("tmo_rdata", rdata, 16'hFFFF);
    end_frame("tmo_end_idle");
`endif

    // Reset while a request is outstanding
    ack_delay = 0;
    start_frame(20'h00555, 4'b0000);
    tick();
    check_val("pre_rst_req", bus_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_outs", {bus_req, bus_we, busy, err}, 32'h0);
    check_val("async_rst_bus", {bus_addr, rdata}, 36'h0);
    tick();
    reset = 1'b0; cs_n = 1'b1;
    tick(3);

    check_val("sb_drained", exp_q.size() + rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
